// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Drives open-collector output-enables only; line levels are read back through a 2-flop synchroniser.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  input  logic       KeyClockIn,
  input  logic       KeyDataIn,
  output logic       KeyClockOE,
  output logic       KeyDataOE,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Terminal values are one short so the clock is held low INHIBIT_CYCLES in total (START included)
  // and Error lands TIMEOUT_CYCLES after the cycle in which the last falling edge was seen.
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_BITS      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE = 3'd6;

  logic [1:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  logic             clk_prev_q;
  logic             clk_s;
  logic             dat_s;
  logic             fe;

  logic [2:0]       state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       idx_q, idx_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             watched;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], KeyClockIn};
      dat_sync_q <= {dat_sync_q[0], KeyDataIn};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fe    = clk_prev_q & ~clk_s;

  assign watched = (state_q == S_BITS) || (state_q == S_STOP) ||
                   (state_q == S_ACK)  || (state_q == S_WAIT_IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    inh_cnt_d = inh_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    if (fe) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LAST) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (TxStart) begin
          shift_d   = {~^TxData, TxData};
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          state_d  = S_START;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      S_START: begin
        clk_oe_d = 1'b0;
        idx_d    = 4'd0;
        to_cnt_d = '0;
        state_d  = S_BITS;
      end
      S_BITS: begin
        if (fe) begin
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b0, shift_q[8:1]};
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'd8) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (fe) begin
          dat_oe_d = 1'b0;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        if (fe) begin
          if (!dat_s) begin
            state_d = S_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // A stalled device aborts the frame; a completion in the same cycle takes precedence.
    if (watched && !fe && (to_cnt_q == TO_LAST) && !done_d && !error_d) begin
      error_d  = 1'b1;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      busy_d   = 1'b0;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign KeyClockOE = clk_oe_q;
  assign KeyDataOE  = dat_oe_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       Clock   = 1'b0;
  logic       Reset   = 1'b0;
  logic [7:0] TxData  = 8'h00;
  logic       TxStart = 1'b0;
  logic       KeyClockIn, KeyDataIn;
  logic       KeyClockOE, KeyDataOE, Busy, Done, Error;
  logic       dev_clk = 1'b1;
  logic       dev_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int clk_low_cnt = 0;
  int err_cyc = 0;
  int overlap_cnt = 0;
  int busy_bad_cnt = 0;
  int last_fall = 0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .TxData     (TxData),
    .TxStart    (TxStart),
    .KeyClockIn (KeyClockIn),
    .KeyDataIn  (KeyDataIn),
    .KeyClockOE (KeyClockOE),
    .KeyDataOE  (KeyDataOE),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error)
  );

  // Open-collector wired-AND of host and device on each line.
  assign KeyClockIn = ~KeyClockOE & dev_clk;
  assign KeyDataIn  = ~KeyDataOE & ~dev_low;

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (Done) done_cnt <= done_cnt + 1;
    if (Error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (KeyClockOE) clk_low_cnt <= clk_low_cnt + 1;
    if (Done && Error) overlap_cnt <= overlap_cnt + 1;
    if ((Done || Error) && Busy) busy_bad_cnt <= busy_bad_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got time %0t expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line levels: start 0, d0..d7 LSB first, odd parity, stop 1.
  function automatic int ref_frame(input logic [7:0] d);
    int ones = 0;
    int f = 0;
    for (int i = 0; i < 8; i++) begin
      ones += int'(d[i]);
      f |= int'(d[i]) << (i + 1);
    end
    if (ones % 2 == 0) f |= 1 << 9;
    f |= 1 << 10;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] d);
    tick(1);
    TxData  = d;
    TxStart = 1'b1;
    tick(1);
    TxStart = 1'b0;
  endtask

  task automatic device(input int n_edges, input bit ack, output int frame);
    int t = 0;
    frame = 0;
    while (!KeyClockOE && t < 200) begin tick(1); t++; end
    while (KeyClockOE && t < 200) begin tick(1); t++; end
    if (t >= 200) begin
      check("clock_release_wait", t, 0);
      return;
    end
    frame |= int'(KeyDataIn);
    for (int i = 1; i <= n_edges; i++) begin
      tick(HALF);
      dev_clk   = 1'b0;
      last_fall = cyc;
      if (i == 11 && ack) dev_low = 1'b1;
      tick(HALF);
      if (i <= 10) frame |= int'(KeyDataIn) << i;
      dev_clk = 1'b1;
      dev_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int d0, input int e0, input int limit);
    int t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < limit) begin tick(1); t++; end
    if (t >= limit) check("end_wait", t, 0);
    tick(3);
  endtask

  task automatic run_tx(input logic [7:0] d, input bit ack, input bit inject);
    int d0, e0, c0, frame;
    d0 = done_cnt;
    e0 = err_cnt;
    c0 = clk_low_cnt;
    send_cmd(d);
    fork
      device(11, ack, frame);
      if (inject) begin
        tick(5);
        TxData  = ~d;
        TxStart = 1'b1;
        tick(1);
        TxStart = 1'b0;
      end
    join
    wait_end(d0, e0, 100);
    check($sformatf("frame_%02h", d), frame, ref_frame(d));
    check("clk_low_cycles", clk_low_cnt - c0, INH);
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("error_pulses", err_cnt - e0, ack ? 0 : 1);
    check("idle_busy_oe", int'({Busy, KeyClockOE, KeyDataOE}), 0);
  endtask

  initial begin
    int d0, e0, frame;
    logic [7:0] rb;

    #2 Reset = 1'b1;
    #2;
    check("reset_outputs", int'({KeyClockOE, KeyDataOE, Busy, Done, Error}), 0);
    tick(3);
    @(negedge Clock);
    Reset = 1'b0;
    tick(2);

    run_tx(8'hF4, 1'b1, 1'b0);
    run_tx(8'hED, 1'b1, 1'b1);
    run_tx(8'h00, 1'b1, 1'b0);
    run_tx(8'hFF, 1'b1, 1'b0);
    run_tx(8'($urandom_range(0, 255)), 1'b0, 1'b0);

    // Device goes silent after the fourth clock.
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'h3C);
    device(4, 1'b1, frame);
    wait_end(d0, e0, 400);
    check("timeout_latency", err_cyc - last_fall, TMO + 2);
    check("timeout_error", err_cnt - e0, 1);
    check("timeout_done", done_cnt - d0, 0);
    check("timeout_idle", int'({Busy, KeyClockOE, KeyDataOE}), 0);
    run_tx(8'($urandom_range(0, 255)), 1'b1, 1'b0);

    // Asynchronous reset while bits are on the line.
    rb = 8'h5A;
    send_cmd(rb);
    device(3, 1'b1, frame);
    check("bits_busy", int'(Busy), 1);
    check("bits_data_oe", int'(KeyDataOE), ((rb >> 2) & 8'd1) != 0 ? 0 : 1);
    #3 Reset = 1'b1;
    #1;
    check("async_reset", int'({KeyClockOE, KeyDataOE, Busy, Done, Error}), 0);
    @(negedge Clock);
    Reset = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    tick(50);
    check("post_reset_quiet", (done_cnt - d0) + (err_cnt - e0), 0);

    for (int k = 0; k < 4; k++) begin
      run_tx(8'($urandom_range(0, 255)), 1'b1, (k % 2) == 1);
    end

    check("done_error_overlap", overlap_cnt, 0);
    check("busy_during_pulse", busy_bad_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter for the keyboard interface. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the open-collector PS/2 clock and data lines. It is the counterpart of the keyboard receive path and shares the same physical lines, so it drives output-enables rather than levels. It sits beside the receive front-end; the keyboard clock input comes straight from the pin and is synchronised internally.

Parameters:
INHIBIT_CYCLES, 5000, system clocks the clock line is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, maximum system clocks to wait for any device clock edge or final idle (20 ms at 50 MHz).

Ports:
Clock  input  1  system clock; all logic on rising edge.
Reset  input  1  asynchronous, active-high reset.
TxData  input  8  command byte, sampled when TxStart is accepted.
TxStart  input  1  one-cycle request; accepted only when Busy=0.
KeyClockIn  input  1  raw PS/2 clock pin level.
KeyDataIn  input  1  raw PS/2 data pin level.
KeyClockOE  output  1  1 = pull PS/2 clock low; 0 = release.
KeyDataOE  output  1  1 = pull PS/2 data low; 0 = release.
Busy  output  1  high from acceptance until Done or Error.
Done  output  1  one-cycle pulse on a successful, acknowledged transfer.
Error  output  1  one-cycle pulse on timeout or missing acknowledge.

Behaviour:
- Reset: KeyClockOE=0, KeyDataOE=0, Busy=0, Done=0, Error=0, state IDLE, counters 0. Both lines are released immediately, even mid-transfer.
- Sync: KeyClockIn and KeyDataIn each pass through 2 flops. A falling edge (fe) is prev=1, cur=1→0 on the synced clock. fe lags the pin by 2–3 cycles.
- Frame latch on acceptance: shift register = {odd parity, TxData}. Parity = ~^TxData.
- IDLE: Busy=0. TxStart=1 → latch the frame, Busy=1, KeyClockOE=1, go to INHIBIT. TxStart while Busy=1 is ignored.
- INHIBIT: count INHIBIT_CYCLES with KeyClockOE=1. On terminal count, set KeyDataOE=1 (start bit 0) and go to START.
- START: hold for one cycle with both OE=1, then KeyClockOE=0. Reset the bit index to 0 and go to BITS.
- BITS: on each fe, KeyDataOE = ~shift[0] (drive low for a 0 bit), then shift right and increment the index. fe 1–8 present d0..d7 and fe 9 presents parity. After fe 9, go to STOP.
- STOP: on fe 10, KeyDataOE=0 (stop bit 1, line released). Go to ACK.
- ACK: on fe 11, sample synced data. 0 → go to WAIT_IDLE. 1 → Error pulse and go to IDLE.
- WAIT_IDLE: when synced clock=1 and data=1, pulse Done and go to IDLE.
- Timeout: in BITS, STOP, ACK and WAIT_IDLE, a counter clears on every fe (and on state entry). If it reaches TIMEOUT_CYCLES: Error pulse, both OE=0, go to IDLE.
- Busy drops in the same cycle Done or Error is asserted. Done and Error are never both high.
- KeyClockOE is 1 only in INHIBIT and START. KeyDataOE never changes except on fe, on INHIBIT terminal count, or on abort.
- Counter widths are sized by $clog2 of each parameter. No wrap: counters saturate at the terminal value.

Test Plan:
- INHIBIT_CYCLES=20, TIMEOUT=200. TxStart with 0xF4; a device model clocks 11 edges (period 40 cycles) and pulls data low at edge 11. Required: clock held low exactly 20 cycles, start 0. Sampled bits on rising edges: d0..d7 = 0,0,1,0,1,1,1,1, parity 0, stop 1. Done pulses once, Error=0.
- TxStart with 0xED. Required: bits 1,0,1,1,0,1,1,1, parity 1, Done.
- TxStart with 0x00 → parity 1; with 0xFF → parity 1. Both complete with Done.
- Device does not pull data low at edge 11. Required: Error pulses 1 cycle, Done=0, Busy=0, both OE=0.
- Device stops clocking after edge 4. Required: Error exactly 200 cycles after the last fe, both lines released. A new TxStart afterwards completes normally.
- Assert Reset during BITS. Required: both OE=0 asynchronously, Busy=0. A second TxStart during Busy is ignored: the frame sent is still the first TxData.
